mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port program/data memory between the instruction fetch unit (instr_* handshake of the fetch stage) and the load/store unit (data_*).
- Request/grant/valid protocol on all sides; addresses held stable until grant, responses returned in order.
- Fixed priority data over instruction, with a starvation guard for fetch. Tracks outstanding transactions so each response is routed back to its owner.

Parameters:
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions on mem port (1..4).
- STARVE_LIMIT, 4, consecutive data grants while instr_req is pending before fetch is forced ahead.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- instr_req  in  1  fetch request
- instr_addr  in  32  fetch word address
- instr_gnt  out  1  fetch request accepted
- instr_valid  out  1  fetch response valid
- instr_rdata  out  32  fetch read data
- instr_err  out  1  fetch bus error
- data_req  in  1  LSU request
- data_we  in  1  LSU write enable
- data_be  in  4  LSU byte enables
- data_addr  in  32  LSU address
- data_wdata  in  32  LSU write data
- data_gnt  out  1  LSU request accepted
- data_valid  out  1  LSU response valid
- data_rdata  out  32  LSU read data
- data_err  out  1  LSU bus error
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable (0 for fetch)
- mem_be  out  4  byte enables (4'hF for fetch)
- mem_addr  out  32  memory address
- mem_wdata  out  32  write data (0 for fetch)
- mem_gnt  in  1  memory accepted request
- mem_valid  in  1  memory response valid
- mem_rdata  in  32  memory read data
- mem_err  in  1  memory bus error
- outstanding_cnt  out  3  current outstanding count
- spurious_rsp  out  1  one-cycle pulse: mem_valid with no outstanding transaction

Behaviour:
- Reset: owner FIFO empty, outstanding_cnt=0, starve counter=0, spurious_rsp=0. All gnt/valid outputs low; mem_req=0.
- Capacity: can_issue = (outstanding_cnt < MAX_OUTSTANDING) | mem_valid.
- Request selection is combinational each cycle:
  - force_instr = instr_req & (starve_cnt == STARVE_LIMIT).
  - sel_data = data_req & ~force_instr; otherwise sel_instr = instr_req.
- mem_req = can_issue & (data_req | instr_req).
- mem_addr/we/be/wdata are muxed from the selected master.
- Grants are zero-latency pass-through:
  - data_gnt = mem_gnt & mem_req & sel_data.
  - instr_gnt = mem_gnt & mem_req & sel_instr.
  - A non-selected master sees gnt=0 and must hold its request.
- Selection may change between cycles while mem_gnt=0. The mem port therefore sees an address switch only between unaccepted requests.
- Owner FIFO:
  - Depth MAX_OUTSTANDING, 1-bit entries (1=data).
  - Push on any grant; pop on mem_valid when not empty.
  - Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo depth.
- Response routing:
  - data_valid = mem_valid & ~empty & head.
  - instr_valid = mem_valid & ~empty & ~head.
  - rdata/err are broadcast to both masters and are meaningful only with the corresponding valid.
- mem_valid while empty: no valid output, spurious_rsp=1 for that cycle, FIFO unchanged.
- Starve counter:
  - Increments on a data grant while instr_req=1, saturating at STARVE_LIMIT.
  - Clears on any instr grant, or when instr_req=0.
- Response latency: 0 cycles added; valid/rdata are combinational from mem_*.
- Reset mid-operation: all state is cleared asynchronously; in-flight responses after reset release are flagged spurious.

Decomposition:
- Shared package riscv_pkg holds owner_e (OWNER_INSTR=1'b0, OWNER_DATA=1'b1) and the fetch default byte enables constant BE_WORD=4'hF.
- One sub-module, arb_owner_fifo: a small counter-based FIFO with push/pop/full/empty/head/count. The arbiter top instantiates it.

Test Plan:
- Only instr_req=1, addr 0x100, mem_gnt=1 every cycle, mem_valid one cycle later with rdata 0xDEADBEEF:
  - instr_gnt each cycle.
  - instr_valid with 0xDEADBEEF.
  - mem_be=4'hF, mem_we=0.
- data_req and instr_req both high, mem_gnt=1:
  - data granted first (addr 0x2000, we=1, be=4'h3).
  - The response returns on data_valid only, with instr_valid=0.
- Continuous data_req plus instr_req, STARVE_LIMIT=4:
  - 4 data grants, then exactly one instr_gnt, then data resumes.
  - Starve counter returns to 0.
- Interleaved grants data, instr, with mem_valid delayed 3 cycles and MAX_OUTSTANDING=2:
  - Third request is blocked (mem_req=0) until the first response.
  - Responses route data then instr in order.
- mem_valid pulsed with outstanding_cnt=0:
  - spurious_rsp=1 for one cycle.
  - No instr_valid/data_valid; count stays 0.
- reset_n asserted with 2 outstanding:
  - outstanding_cnt=0, all gnt/valid low immediately.
  - A following mem_valid raises spurious_rsp.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the memory port arbiter
// Provides owner_e, which tags each granted transaction with the master that
// receives its response, and BE_WORD, the byte enables used for fetches.
package riscv_pkg;
  typedef enum logic {OWNER_INSTR = 1'b0, OWNER_DATA = 1'b1} owner_e;
  localparam logic [3:0] BE_WORD = 4'hF;
endpackage

// File: rtl/arb_owner_fifo.sv
// arb_owner_fifo: in-order record of which master owns each outstanding transaction
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   push, din        record the owner of a newly granted transaction
//   pop              retire the oldest transaction (ignored while empty)
//   head             owner of the oldest outstanding transaction
//   full, empty      occupancy flags
//   count            number of outstanding transactions
module arb_owner_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  owner_e     din,
  input  logic       pop,
  output owner_e     head,
  output logic       full,
  output logic       empty,
  output logic [2:0] count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  owner_e slots [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic push_en, pop_en;
  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);
  assign head    = slots[rptr];
  assign full    = count == 3'(DEPTH);
  assign empty   = count == 3'd0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_en) wptr <= inc(wptr);
      if (pop_en) rptr <= inc(rptr);
      count <= count + 3'(push_en) - 3'(pop_en);
    end
  always_ff @(posedge clk)
    if (push_en) slots[wptr] <= din;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and the load/store unit
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   instr_req/addr            fetch request; instr_gnt accepts it
//   instr_valid/rdata/err     fetch response
//   data_req/we/be/addr/wdata LSU request; data_gnt accepts it
//   data_valid/rdata/err      LSU response
//   mem_req/we/be/addr/wdata  request to memory; mem_gnt accepts it
//   mem_valid/rdata/err       in-order memory response
//   outstanding_cnt           granted-but-unanswered transactions
//   spurious_rsp              mem_valid seen with nothing outstanding
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_gnt,
  output logic        instr_valid,
  output logic [31:0] instr_rdata,
  output logic        instr_err,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_valid,
  output logic [31:0] data_rdata,
  output logic        data_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic [2:0]  outstanding_cnt,
  output logic        spurious_rsp
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;
  logic can_issue, force_instr, sel_data, sel_instr, pop, full, empty;
  owner_e head;
  always_comb begin
    // A response retiring this cycle frees a slot for a same-cycle issue.
    can_issue   = ~full | mem_valid;
    force_instr = instr_req & (starve_cnt == SW'(STARVE_LIMIT));
    sel_data    = data_req & ~force_instr;
    sel_instr   = instr_req & ~sel_data;
    mem_req     = reset_n & can_issue & (data_req | instr_req);
    mem_we      = sel_data & data_we;
    mem_be      = sel_data ? data_be : BE_WORD;
    mem_addr    = sel_data ? data_addr : instr_addr;
    mem_wdata   = sel_data ? data_wdata : 32'h0;
    data_gnt    = mem_gnt & mem_req & sel_data;
    instr_gnt   = mem_gnt & mem_req & sel_instr;
    pop         = mem_valid & ~empty;
    data_valid  = pop & (head == OWNER_DATA);
    instr_valid = pop & (head == OWNER_INSTR);
    spurious_rsp = reset_n & mem_valid & empty;
  end
  assign instr_rdata = mem_rdata;
  assign instr_err   = mem_err;
  assign data_rdata  = mem_rdata;
  assign data_err    = mem_err;
  // Counts data grants that overtook a waiting fetch; saturates at the limit.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) starve_cnt <= '0;
    else if (instr_gnt | ~instr_req) starve_cnt <= '0;
    else if (data_gnt && starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
  arb_owner_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (instr_gnt | data_gnt),
    .din     (data_gnt ? OWNER_DATA : OWNER_INSTR),
    .pop     (pop),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (outstanding_cnt)
  );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a behavioural memory and arbitration model
module tb_mem_port_arbiter;
  import riscv_pkg::*;
  localparam int MAXO = 2;
  localparam int LIM  = 4;
  logic clk = 1'b0, reset_n = 1'b0;
  logic instr_req = 1'b0, data_req = 1'b0, data_we = 1'b0, mem_gnt = 1'b0;
  logic mem_valid = 1'b0, mem_err = 1'b0;
  logic [3:0] data_be = 4'h0;
  logic [31:0] instr_addr = '0, data_addr = '0, data_wdata = '0, mem_rdata = '0;
  logic instr_gnt, instr_valid, instr_err, data_gnt, data_valid, data_err;
  logic mem_req, mem_we, spurious_rsp;
  logic [3:0] mem_be;
  logic [31:0] instr_rdata, data_rdata, mem_addr, mem_wdata;
  logic [2:0] outstanding_cnt;
  always #5 clk = ~clk;
  mem_port_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
    .instr_valid(instr_valid), .instr_rdata(instr_rdata), .instr_err(instr_err),
    .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_valid(data_valid),
    .data_rdata(data_rdata), .data_err(data_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_valid(mem_valid),
    .mem_rdata(mem_rdata), .mem_err(mem_err),
    .outstanding_cnt(outstanding_cnt), .spurious_rsp(spurious_rsp)
  );
  typedef struct {bit owner; logic [31:0] rdata; bit err;} exp_t;
  typedef struct {logic [31:0] rdata; bit err; int ready;} rsp_t;
  exp_t sb[$];
  rsp_t mq[$];
  int total = 0, bad = 0, cyc = 0, streak = 0, spur_cnt = 0;
  int delay_lo = 1, delay_hi = 1;
  bit en_rsp = 1'b1, from_mq = 1'b0, fixed_en = 1'b0, gi = 1'b0, gd = 1'b0;
  logic [31:0] fixed_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return fixed_en ? fixed_rdata : (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // One clock cycle: check arbitration against the model, then advance the
  // model and the memory responder.
  task automatic tick();
    bit exp_req, exp_data, g;
    int nstreak;
    logic [31:0] a;
    exp_t e;
    rsp_t r;
    @(negedge clk);
    exp_req  = reset_n && (sb.size() < MAXO || mem_valid) && (instr_req || data_req);
    exp_data = data_req && !(instr_req && streak == LIM);
    chk("outstanding_cnt", 32'(outstanding_cnt), 32'(sb.size()));
    chk("mem_req", 32'(mem_req), 32'(exp_req));
    chk("spurious_rsp", 32'(spurious_rsp), 32'(reset_n && mem_valid && sb.size() == 0));
    if (spurious_rsp) spur_cnt++;
    if (exp_req) begin
      chk("mem_addr", mem_addr, exp_data ? data_addr : instr_addr);
      chk("mem_we", 32'(mem_we), 32'(exp_data && data_we));
      chk("mem_be", 32'(mem_be), exp_data ? 32'(data_be) : 32'hF);
      chk("mem_wdata", mem_wdata, exp_data ? data_wdata : 32'h0);
    end
    g  = exp_req && mem_gnt;
    gd = g && exp_data;
    gi = g && !exp_data;
    chk("data_gnt", 32'(data_gnt), 32'(gd));
    chk("instr_gnt", 32'(instr_gnt), 32'(gi));
    if (mem_valid && from_mq) void'(mq.pop_front());
    if (g) begin
      a = exp_data ? data_addr : instr_addr;
      e = '{owner: gd, rdata: mem_word(a), err: fixed_en ? 1'b0 : a[4]};
      r = '{rdata: e.rdata, err: e.err, ready: cyc + int'($urandom_range(delay_hi, delay_lo))};
    end
    nstreak = (!reset_n || gi || !instr_req) ? 0 : (gd && streak < LIM) ? streak + 1 : streak;
    @(posedge clk);
    cyc++;
    streak = nstreak;
    if (g) begin
      sb.push_back(e);
      mq.push_back(r);
    end
    #1;
    from_mq   = en_rsp && reset_n && mq.size() > 0 && mq[0].ready <= cyc;
    mem_valid = from_mq;
    mem_rdata = from_mq ? mq[0].rdata : $urandom();
    mem_err   = from_mq ? mq[0].err : 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    instr_req = 1'b0;
    data_req  = 1'b0;
    while ((sb.size() > 0 || mq.size() > 0) && k < 50) begin
      tick();
      k++;
    end
    chk("drain_timeout", 32'(sb.size() + mq.size()), 32'h0);
    tick();
  endtask

  // Monitor: retires the oldest expected response whenever the memory answers.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!mem_valid) begin
      if (instr_valid || data_valid) chk("valid_idle", {30'b0, instr_valid, data_valid}, 32'h0);
    end else if (reset_n) begin
      if (sb.size() == 0) chk("valid_spurious", {30'b0, instr_valid, data_valid}, 32'h0);
      else begin
        e = sb.pop_front();
        chk("rsp_route", {30'b0, instr_valid, data_valid}, e.owner ? 32'h1 : 32'h2);
        chk("rsp_rdata", e.owner ? data_rdata : instr_rdata, e.rdata);
        chk("rsp_err", 32'(e.owner ? data_err : instr_err), 32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, sp0;
    string seq;
    #1;
    chk("rst_cnt", 32'(outstanding_cnt), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_spurious", 32'(spurious_rsp), 32'h0);
    chk("rst_gnt_valid", {28'b0, instr_gnt, data_gnt, instr_valid, data_valid}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    // Fetch only, response one cycle after each grant.
    fixed_en = 1'b1;
    fixed_rdata = 32'hDEADBEEF;
    instr_req = 1'b1;
    instr_addr = 32'h100;
    mem_gnt = 1'b1;
    n = 0;
    repeat (6) begin
      tick();
      if (gi) n++;
    end
    chk("t1_instr_grants", 32'(n), 32'd6);
    drain();
    fixed_en = 1'b0;
    // Both masters request: data wins first.
    data_req = 1'b1; data_we = 1'b1; data_be = 4'h3;
    data_addr = 32'h2000; data_wdata = 32'h12345678;
    instr_req = 1'b1; instr_addr = 32'h104;
    tick();
    chk("t2_data_first", 32'(gd), 32'h1);
    chk("t2_instr_wait", 32'(gi), 32'h0);
    data_req = 1'b0;
    tick();
    chk("t2_instr_next", 32'(gi), 32'h1);
    drain();
    // Starvation guard.
    seq = "";
    data_req = 1'b1;
    instr_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (gd) begin seq = {seq, "D"}; data_addr += 4; end
      else if (gi) begin seq = {seq, "I"}; instr_addr += 4; end
      else seq = {seq, "-"};
    end
    total++;
    if (seq != "DDDDIDDDDI") begin
      bad++;
      $display("FAIL starve_seq: got %s expected DDDDIDDDDI", seq);
    end
    drain();
    // Capacity limit with slow responses.
    delay_lo = 3; delay_hi = 3;
    data_req = 1'b1; instr_req = 1'b1;
    tick();
    chk("t4_data_gnt", 32'(gd), 32'h1);
    data_req = 1'b0;
    tick();
    chk("t4_instr_gnt", 32'(gi), 32'h1);
    instr_req = 1'b0; data_req = 1'b1; data_addr = 32'h3000;
    n = 0;
    do begin
      tick();
      n++;
    end while (!gd && n < 10);
    chk("t4_block_cycles", 32'(n), 32'd2);
    drain();
    // Response with nothing outstanding.
    sp0 = spur_cnt;
    mem_valid = 1'b1; from_mq = 1'b0; mem_rdata = 32'h0BAD0BAD;
    tick();
    tick();
    chk("t5_spurious_pulses", 32'(spur_cnt - sp0), 32'd1);
    // Reset with two transactions in flight.
    delay_lo = 1; delay_hi = 1;
    en_rsp = 1'b0;
    data_req = 1'b1; instr_req = 1'b1; data_addr = 32'h4000;
    tick();
    tick();
    chk("t6_cnt_before", 32'(outstanding_cnt), 32'd2);
    reset_n = 1'b0;
    #1;
    chk("t6_cnt_reset", 32'(outstanding_cnt), 32'h0);
    chk("t6_gnt_valid", {27'b0, mem_req, instr_gnt, data_gnt, instr_valid, data_valid}, 32'h0);
    sb.delete();
    tick();
    tick();
    reset_n = 1'b1;
    data_req = 1'b0; instr_req = 1'b0;
    en_rsp = 1'b1;
    sp0 = spur_cnt;
    drain();
    chk("t6_spurious_after", 32'(spur_cnt - sp0), 32'd2);
    // Random traffic.
    delay_lo = 1; delay_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      if (gi || !instr_req) begin
        instr_req  = $urandom_range(99, 0) < 60;
        instr_addr = $urandom() & 32'h0000FFFC;
      end
      if (gd || !data_req) begin
        data_req   = $urandom_range(99, 0) < 50;
        data_we    = 1'($urandom_range(1, 0));
        data_be    = 4'($urandom_range(15, 1));
        data_addr  = $urandom() & 32'h0000FFFC;
        data_wdata = $urandom();
      end
      mem_gnt = $urandom_range(99, 0) < 70;
      tick();
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
